demux_deser8: RTL and testbench
===============================

# demux_deser8

Serial-to-parallel bit deserializer: accepts one bit per qualified clock and steers each bit through a 1-to-8 demultiplexer into an 8-bit accumulator, indexed by a 3-bit bit counter. Once 8 bits have arrived, it presents the assembled byte on a valid/ready output holding register. It is the receive-side counterpart of the 8-to-1 mux serializer path. It feeds bytes to the ALU operand registers from a single-wire source.

## Interface
- LSB_FIRST, 1, 1: first accepted bit lands in out_byte[0]. 0: first accepted bit lands in out_byte[7].
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous abort of the partial byte
- in_valid  in  1  in_bit is valid this cycle; always accepted (no backpressure)
- in_bit  in  1  serial data bit
- out_ready  in  1  consumer accepts out_byte this cycle
- out_valid  out  1  out_byte holds an unconsumed byte
- out_byte  out  8  assembled byte
- busy  out  1  partial byte in progress (state RECV)
- bit_idx  out  3  count of bits accepted in the current byte (0..7)
- overrun  out  1  sticky: a completed byte was dropped

## Operation
- States:
  - IDLE: cnt=0, no partial byte.
  - RECV: 1..7 bits held.
- Bit acceptance (in_valid=1, clear=0):
  - Demux write: acc[d] <= in_bit, where d = cnt if LSB_FIRST, else 7-cnt. All other acc bits hold.
  - cnt increments modulo 8.
  - IDLE->RECV on the first bit. RECV stays on bits 2..7.
  - On the 8th bit (cnt==7), cnt wraps to 0 and state returns to IDLE. The completed byte is the acc contents with the 8th bit merged.
- Output register:
  - Consume event: out_valid & out_ready.
  - Completion with out_valid=0, or completion coincident with a consume: out_byte <= completed byte, out_valid <= 1.
  - Completion with out_valid=1 & out_ready=0: completed byte is dropped; out_byte and out_valid hold; overrun <= 1.
  - Consume without completion: out_valid <= 0. out_byte holds its last value.
- clear=1:
  - cnt <= 0, acc <= 0, state <= IDLE, overrun <= 0.
  - Any in_valid bit in the same cycle is ignored.
  - out_valid and out_byte are unaffected; a pending byte may still be consumed in the same cycle.
- rst=1 (priority over everything): cnt, acc, out_byte <= 0; out_valid, overrun <= 0; state <= IDLE.
- busy = (state==RECV). bit_idx = cnt. Both are registered-state derived, with no combinational path from inputs.
- in_valid=0: no state change, except output consume.

## Timing
- Reset values: out_valid=0, out_byte=8'h00, busy=0, bit_idx=0, overrun=0.
- Latency: out_valid rises in the cycle after the edge that samples the 8th bit. This is 1 clock after the 8th bit, with no extra pipeline stage.
- Gaps: back-to-back bytes with in_valid held high sustain 1 byte per 8 clocks. Gaps in in_valid stretch the byte without losing bits.
- Overrun: a consumer must take out_byte within 8 accepted bits of out_valid rising, or overrun.
- Reset mid-byte discards the partial byte. The first post-reset bit is bit 0 of a new byte.
- No combinational paths from inputs to outputs.

## Test plan
- LSB_FIRST=1, rst, then stream bits 1,0,1,0,0,1,0,1 with in_valid=1 and out_ready=0 -> out_valid=1 one cycle after 8th bit, out_byte=8'hA5, busy=0, bit_idx=0.
- LSB_FIRST=0, same bit stream -> out_byte=8'hA5 reversed, i.e. 8'hA5 bit order flipped to 8'hA5 for palindrome; use stream 1,1,0,0,0,0,0,1 instead -> out_byte=8'hC1; with LSB_FIRST=1 the same stream -> 8'h83.
- Continuous 16 bits encoding 8'h3C then 8'hF0, out_ready=1 held -> out_valid pulses 1 cycle per byte, values 3C then F0, overrun=0.
- Two bytes (8'h11, 8'h22) with out_ready=0 -> out_byte stays 8'h11, overrun=1. Assert clear -> overrun=0 and out_byte still 8'h11. Then out_ready=1 for one cycle -> out_valid=0.
- Send 5 bits, pulse clear (with in_valid=1 that cycle), then send 8 bits of 8'h5A -> out_byte=8'h5A with no residue from the aborted bits; bit_idx reads 5 before clear and 0 after.
- Completion coincident with consume of a pending byte: pending 8'h01, 8th bit of 8'h02 arrives with out_ready=1 -> next cycle out_valid=1, out_byte=8'h02, overrun=0.
- Assert rst at bit 3 while out_valid=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/demux_deser8.sv
// Serial-to-parallel deserializer: a 1-to-8 bit demux fills an accumulator,
// and each completed byte is handed to a valid/ready output holding register.
module demux_deser8 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       busy,
    output logic [2:0] bit_idx,
    output logic       overrun
);

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    out_byte_q, out_byte_d;
    logic            out_valid_q, out_valid_d;
    logic            overrun_q, overrun_d;
    logic [CW-1:0]   dst_idx;
    logic            complete;
    logic            consume;

    // State and holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Bit steering, byte completion and output handshake
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        complete    = 1'b0;
        consume     = out_valid_q & out_ready;
        dst_idx     = LSB_FIRST ? cnt_q : (CW'(W - 1) - cnt_q);

        if (clear) begin
            state_d   = IDLE;
            cnt_d     = '0;
            acc_d     = '0;
            overrun_d = 1'b0;
        end else if (in_valid) begin
            acc_d[dst_idx] = in_bit;
            cnt_d          = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                state_d  = IDLE;
                complete = 1'b1;
            end else begin
                state_d = RECV;
            end
        end

        // A completed byte merges the 8th bit, so it is taken from acc_d
        if (complete && (!out_valid_q || consume)) begin
            out_byte_d  = acc_d;
            out_valid_d = 1'b1;
        end else if (complete) begin
            overrun_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign busy      = (state_q == RECV);
    assign bit_idx   = cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_demux_deser8.sv
// Bench for demux_deser8: LSB-first and MSB-first instances share stimulus and
// are checked each cycle against a bit-queue reference model.
module tb_demux_deser8;

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, in_bit, out_ready;
    logic       ov_l, bsy_l, ovr_l, ov_m, bsy_m, ovr_m;
    logic [7:0] ob_l, ob_m;
    logic [2:0] bi_l, bi_m;

    int compared = 0;
    int failed   = 0;

    // Reference model state
    bit         bitq[$];
    logic       m_valid;
    logic [7:0] m_byte_l, m_byte_m;
    logic       m_ovr;

    always #5 clk = ~clk;

    demux_deser8 #(.LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .out_ready(out_ready), .out_valid(ov_l), .out_byte(ob_l), .busy(bsy_l),
        .bit_idx(bi_l), .overrun(ovr_l)
    );

    demux_deser8 #(.LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .out_ready(out_ready), .out_valid(ov_m), .out_byte(ob_m), .busy(bsy_m),
        .bit_idx(bi_m), .overrun(ovr_m)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid_l",   8'(ov_l),  8'(m_valid));
        chk("byte_l",    ob_l,      m_byte_l);
        chk("busy_l",    8'(bsy_l), 8'(bitq.size() != 0));
        chk("idx_l",     8'(bi_l),  8'(bitq.size()));
        chk("overrun_l", 8'(ovr_l), 8'(m_ovr));
        chk("valid_m",   8'(ov_m),  8'(m_valid));
        chk("byte_m",    ob_m,      m_byte_m);
        chk("busy_m",    8'(bsy_m), 8'(bitq.size() != 0));
        chk("idx_m",     8'(bi_m),  8'(bitq.size()));
        chk("overrun_m", 8'(ovr_m), 8'(m_ovr));
    endtask

    // One clock: drive inputs, advance model by the rules, sample 1 after the edge
    task automatic cycle(input logic rs, input logic clr, input logic v,
                         input logic b, input logic rdy);
        logic       consume, done;
        logic [7:0] lsb_val, msb_val;
        rst = rs; clear = clr; in_valid = v; in_bit = b; out_ready = rdy;
        consume = m_valid & rdy;
        done    = 1'b0;
        lsb_val = 8'h00;
        msb_val = 8'h00;
        if (rs) begin
            bitq.delete();
            m_valid = 1'b0; m_byte_l = 8'h00; m_byte_m = 8'h00; m_ovr = 1'b0;
        end else begin
            if (clr) begin
                bitq.delete();
                m_ovr = 1'b0;
            end else if (v) begin
                bitq.push_back(b);
                if (bitq.size() == 8) begin
                    done = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        lsb_val = lsb_val + (8'(bitq[i]) << i);
                        msb_val = msb_val + (8'(bitq[i]) << (7 - i));
                    end
                    bitq.delete();
                end
            end
            if (done && (!m_valid || consume)) begin
                m_byte_l = lsb_val; m_byte_m = msb_val; m_valid = 1'b1;
            end else if (done) begin
                m_ovr = 1'b1;
            end else if (consume) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Serialise val LSB first; out_ready given separately for bits 0..6 and bit 7
    task automatic send_byte(input logic [7:0] val, input logic rdy_body, input logic rdy_last);
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b0, 1'b1, val[i], (i == 7) ? rdy_last : rdy_body);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        logic [7:0] s_a5, s_c1;
        m_valid = 1'b0; m_byte_l = 8'h00; m_byte_m = 8'h00; m_ovr = 1'b0;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_valid", 8'(ov_l), 8'h00);
        chk("reset_byte",  ob_l,     8'h00);

        // Stream 1,0,1,0,0,1,0,1: palindrome, A5 in both bit orders
        s_a5 = 8'hA5;
        send_byte(s_a5, 1'b0, 1'b0);
        chk("a5_lsb", ob_l, 8'hA5);
        chk("a5_msb", ob_m, 8'hA5);
        chk("a5_valid", 8'(ov_l), 8'h01);
        idle(1'b1);

        // Stream 1,1,0,0,0,0,0,1
        s_c1 = 8'h83;
        send_byte(s_c1, 1'b0, 1'b0);
        chk("c1_msb", ob_m, 8'hC1);
        chk("83_lsb", ob_l, 8'h83);
        idle(1'b1);

        // Back-to-back with consumer always ready
        send_byte(8'h3C, 1'b1, 1'b1);
        chk("b2b_3c", ob_l, 8'h3C);
        send_byte(8'hF0, 1'b1, 1'b1);
        chk("b2b_f0", ob_l, 8'hF0);
        chk("b2b_ovr", 8'(ovr_l), 8'h00);
        idle(1'b1);

        // Overrun, then clear keeps the pending byte
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        chk("ovr_byte", ob_l, 8'h11);
        chk("ovr_flag", 8'(ovr_l), 8'h01);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr_ovr", 8'(ovr_l), 8'h00);
        chk("clr_byte", ob_l, 8'h11);
        idle(1'b1);
        chk("consume_valid", 8'(ov_l), 8'h00);

        // Abort a partial byte, clear with in_valid high
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("partial_idx", 8'(bi_l), 8'h05);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("abort_idx", 8'(bi_l), 8'h00);
        send_byte(8'h5A, 1'b0, 1'b0);
        chk("abort_5a", ob_l, 8'h5A);
        idle(1'b1);

        // Completion coincident with consume
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b1);
        chk("coinc_byte", ob_l, 8'h02);
        chk("coinc_valid", 8'(ov_l), 8'h01);
        chk("coinc_ovr", 8'(ovr_l), 8'h00);

        // Reset mid-byte with a byte pending
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_valid", 8'(ov_l), 8'h00);
        chk("rst_byte",  ob_l,     8'h00);
        chk("rst_idx",   8'(bi_l), 8'h00);

        // Randomized traffic, with gaps, stalls, clears and resets
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 9) < 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
